// File: rtl/my_reg_responder.sv
// Register-bank responder: executes read/write requests against DEPTH registers
// and returns in-order responses through a small FIFO.
module my_reg_responder #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 12,
   parameter int RESP_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int PTR_W = $clog2(RESP_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL  = CNT_W'(RESP_DEPTH);
   localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem       [DEPTH];
   logic [DATA_W-1:0] fifo_data [RESP_DEPTH];
   logic              fifo_err  [RESP_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;
   logic              in_range;
   logic [DATA_W-1:0] push_data;

   assign req_ready  = (count != FULL);
   assign resp_valid = (count != '0);
   assign push       = req_valid && req_ready;
   assign pop        = resp_valid && resp_ready;
   assign in_range   = ({1'b0, req_addr} < LIMIT);
   assign push_data  = (in_range && !req_write) ? mem[req_addr] : '0;

   // Head fields are gated by resp_valid so the unreset FIFO storage never shows.
   assign resp_rdata = resp_valid ? fifo_data[rd_ptr] : '0;
   assign resp_err   = resp_valid && fifo_err[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && in_range && req_write) begin
         mem[req_addr] <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= push_data;
         fifo_err[wr_ptr]  <= !in_range;
      end
   end

   // Pointers wrap naturally because RESP_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_my_reg_responder.sv
// Directed self-checking bench for my_reg_responder.
module tb_my_reg_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [3:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int checks = 0;
   int errors = 0;
   logic [31:0] model [12];

   always #5 clk = ~clk;

   my_reg_responder #(
      .ADDR_W(4), .DATA_W(32), .DEPTH(12), .RESP_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
   endtask

   task automatic idleReq();
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 'x;
      req_wdata = 'x;
   endtask

   task automatic checkHead(input string tag, input logic [31:0] data, input logic err);
      checkOutput({tag, "_valid"}, 32'(resp_valid), 32'd1);
      checkOutput({tag, "_rdata"}, resp_rdata, data);
      checkOutput({tag, "_err"}, 32'(resp_err), 32'(err));
   endtask

   // With resp_ready high, the head after each edge is the response just pushed.
   task automatic streamReq(input string tag, input logic w, input logic [3:0] a,
                            input logic [31:0] d, input logic [31:0] exp_data, input logic exp_err);
      applyStimulus(w, a, d);
      tick();
      checkHead(tag, exp_data, exp_err);
   endtask

   task automatic checkEmpty(input string tag);
      checkOutput({tag, "_valid"}, 32'(resp_valid), 32'd0);
      checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 12; i++) model[i] = '0;
      idleReq();

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_rdata", resp_rdata, 32'd0);
      checkOutput("rst_err", 32'(resp_err), 32'd0);
      rst_n = 1'b1;
      tick();
      checkEmpty("idle");
      resp_ready = 1'b1;
      applyStimulus(1'b0, 4'd5, 32'd0);
      #1;
      checkOutput("no_bypass", 32'(resp_valid), 32'd0);
      tick();
      checkHead("rd5", 32'd0, 1'b0);
      idleReq();
      tick();
      checkEmpty("rd5_done");

      // Write then immediate readback
      streamReq("wr3", 1'b1, 4'd3, 32'hDEADBEEF, 32'd0, 1'b0);
      model[3] = 32'hDEADBEEF;
      streamReq("rd3", 1'b0, 4'd3, 32'd0, 32'hDEADBEEF, 1'b0);
      idleReq();
      tick();
      checkEmpty("rd3_done");

      // Out-of-range accesses, then confirm registers untouched
      streamReq("oor_w12", 1'b1, 4'd12, 32'h12345678, 32'd0, 1'b1);
      streamReq("oor_r12", 1'b0, 4'd12, 32'd0, 32'd0, 1'b1);
      streamReq("oor_r15", 1'b0, 4'd15, 32'd0, 32'd0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         streamReq($sformatf("scan_rd%0d", i), 1'b0, 4'(i), 32'd0, model[i], 1'b0);
      end
      idleReq();
      tick();
      checkEmpty("scan_done");

      // Streaming writes: one push and one pop every cycle
      for (int i = 0; i < 12; i++) begin
         streamReq($sformatf("stream_wr%0d", i), 1'b1, 4'(i), 32'h1000_0000 + 32'(i), 32'd0, 1'b0);
         model[i] = 32'h1000_0000 + 32'(i);
      end
      idleReq();
      tick();
      checkEmpty("stream_done");

      // Backpressure until full, then drain
      resp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 4'(i), 32'd0);
         checkOutput($sformatf("bp_ready%0d", i), 32'(req_ready), 32'd1);
         tick();
      end
      checkOutput("full_ready", 32'(req_ready), 32'd0);
      checkHead("full_head", model[0], 1'b0);
      applyStimulus(1'b0, 4'd4, 32'd0);
      tick();
      checkOutput("full_hold_ready", 32'(req_ready), 32'd0);
      checkHead("full_hold_head", model[0], 1'b0);
      resp_ready = 1'b1;
      tick();
      checkOutput("drain_ready", 32'(req_ready), 32'd1);
      checkHead("drain1", model[1], 1'b0);
      tick();
      checkHead("drain2", model[2], 1'b0);
      applyStimulus(1'b0, 4'd5, 32'd0);
      tick();
      checkHead("drain3", model[3], 1'b0);
      idleReq();
      tick();
      checkHead("drain4", model[4], 1'b0);
      tick();
      checkHead("drain5", model[5], 1'b0);
      tick();
      checkEmpty("drain_done");

      // Asynchronous reset with responses queued
      resp_ready = 1'b0;
      applyStimulus(1'b1, 4'd7, 32'hA5A5A5A5);
      tick();
      applyStimulus(1'b0, 4'd7, 32'd0);
      tick();
      applyStimulus(1'b0, 4'd0, 32'd0);
      tick();
      idleReq();
      checkHead("queued", 32'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkEmpty("async_rst");
      checkOutput("async_rst_rdata", resp_rdata, 32'd0);
      checkOutput("async_rst_err", 32'(resp_err), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) model[i] = '0;
      resp_ready = 1'b1;
      streamReq("post_rst_rd7", 1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
      idleReq();
      tick();
      checkEmpty("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
